// File: rtl/atsc_deint_pkg.sv
// Shared constants and branch geometry for the ATSC convolutional deinterleaver.
package atsc_deint_pkg;
  localparam int B         = 52;
  localparam int M         = 4;
  localparam int SEG_LEN   = 207;
  localparam int MEM_DEPTH = 5304;
  localparam int ADDR_W    = 13;

  // Delay of branch k in branch visits; the last branch is a straight wire.
  function automatic int delay(input int k);
    return (B - 1 - k) * M;
  endfunction

  // Start of branch k's region: M * sum_{j<k} (B-1-j), closed form.
  function automatic int base_addr(input int k);
    return M * (k * (B - 1) - (k * (k - 1)) / 2);
  endfunction
endpackage

// File: rtl/atsc_deinterleaver_if.sv
// Byte-wide AXI-stream bundle used on both sides of the deinterleaver.
interface atsc_deinterleaver_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  logic       tuser;
  logic       tlast;

  modport master (output tdata, tvalid, tuser, tlast, input  tready);
  modport slave  (input  tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/atsc_deint_ram.sv
// Single-port read-first RAM holding every branch's delay line.
module atsc_deint_ram
  import atsc_deint_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);
  logic [7:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      rdata     <= mem[addr];
      mem[addr] <= wdata;
    end
  end
endmodule

// File: rtl/atsc_deinterleaver.sv
// ATSC convolutional deinterleaver: per-branch circular delay lines in one RAM,
// one output register stage, 207-byte segment framing and alignment checking.
module atsc_deinterleaver
  import atsc_deint_pkg::*;
(
  input  logic                  ce_clk,
  input  logic                  ce_rst,
  atsc_deinterleaver_if.slave   in_s,
  atsc_deinterleaver_if.master  out_m,
  output logic [15:0]           seg_err_cnt
);
  localparam int KW = $clog2(B);
  localparam int CW = $clog2(SEG_LEN);
  localparam logic [KW-1:0] K_LAST = KW'(B - 1);
  localparam logic [CW-1:0] C_LAST = CW'(SEG_LEN - 1);

  logic [ADDR_W-1:0] base_lut [B];
  logic [7:0]        dly_lut  [B];
  for (genvar g = 0; g < B; g++) begin : g_lut
    assign base_lut[g] = ADDR_W'(base_addr(g));
    assign dly_lut[g]  = 8'(delay(g));
  end

  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] c_q, c_d;
  logic [7:0]    ptr_q [B];
  logic [7:0]    ptr_d [B];
  logic [B-1:0]  filled_q, filled_d;
  logic          out_vld_q, out_vld_d, use_ram_q, use_ram_d, hit_q, hit_d;
  logic          last_q, last_d, user_q, user_d;
  logic [7:0]    byp_q, byp_d;
  logic [15:0]   err_q, err_d;

  logic              in_rdy, xfer, seg_end, ram_en;
  logic [KW-1:0]     kk;
  logic [CW-1:0]     cc;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_rdata;

  // A field sync applies to the byte carrying it, not the next one.
  assign in_rdy      = !out_vld_q || out_m.tready;
  assign in_s.tready = in_rdy;
  assign xfer        = in_s.tvalid && in_rdy;
  assign kk          = in_s.tuser ? '0 : k_q;
  assign cc          = in_s.tuser ? '0 : c_q;
  assign seg_end     = (cc == C_LAST);
  assign ram_en      = xfer && (kk != K_LAST);
  assign ram_addr    = base_lut[kk] + ADDR_W'(ptr_q[kk]);

  atsc_deint_ram u_ram (
    .clk   (ce_clk),
    .en    (ram_en),
    .addr  (ram_addr),
    .wdata (in_s.tdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    k_d       = k_q;
    c_d       = c_q;
    ptr_d     = ptr_q;
    filled_d  = filled_q;
    out_vld_d = out_vld_q && !out_m.tready;
    use_ram_d = use_ram_q;
    hit_d     = hit_q;
    byp_d     = byp_q;
    last_d    = last_q;
    user_d    = user_q;
    err_d     = err_q;
    if (xfer) begin
      out_vld_d = 1'b1;
      use_ram_d = (kk != K_LAST);
      hit_d     = filled_q[kk];
      byp_d     = in_s.tdata;
      last_d    = seg_end;
      user_d    = in_s.tuser;
      k_d       = (kk == K_LAST) ? '0 : kk + 1'b1;
      c_d       = seg_end ? '0 : cc + 1'b1;
      if ((in_s.tlast != seg_end) && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
      if (kk != K_LAST) begin
        if (ptr_q[kk] == dly_lut[kk] - 8'd1) begin
          ptr_d[kk]    = '0;
          filled_d[kk] = 1'b1;
        end else begin
          ptr_d[kk] = ptr_q[kk] + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      k_q       <= '0;
      c_q       <= '0;
      for (int i = 0; i < B; i++) ptr_q[i] <= '0;
      filled_q  <= '0;
      out_vld_q <= 1'b0;
      use_ram_q <= 1'b0;
      hit_q     <= 1'b0;
      byp_q     <= '0;
      last_q    <= 1'b0;
      user_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      k_q       <= k_d;
      c_q       <= c_d;
      ptr_q     <= ptr_d;
      filled_q  <= filled_d;
      out_vld_q <= out_vld_d;
      use_ram_q <= use_ram_d;
      hit_q     <= hit_d;
      byp_q     <= byp_d;
      last_q    <= last_d;
      user_q    <= user_d;
      err_q     <= err_d;
    end
  end

  // RAM read register only moves on a transfer, so this mux holds under stall.
  assign out_m.tdata  = !use_ram_q ? byp_q : (hit_q ? ram_rdata : 8'h00);
  assign out_m.tvalid = out_vld_q;
  assign out_m.tlast  = last_q;
  assign out_m.tuser  = user_q;
  assign seg_err_cnt  = err_q;
endmodule

// File: tb/tb_atsc_deinterleaver.sv
// Bench for atsc_deinterleaver: delay-line reference model, reference interleaver
// round trip, backpressure replay, misalignment counting and async reset.
module tb_atsc_deinterleaver;
  localparam int NB   = 52;
  localparam int NM   = 4;
  localparam int SEG  = 207;
  localparam int FILL = 204 * 52;
  localparam int RT_N = 11000;

  typedef logic [7:0] bq_t [$];
  typedef struct packed { logic [7:0] d; logic l; logic u; } beat_t;

  logic        ce_clk = 1'b0;
  logic        ce_rst = 1'b1;
  logic [15:0] seg_err_cnt;

  atsc_deinterleaver_if in_if();
  atsc_deinterleaver_if out_if();

  atsc_deinterleaver dut (
    .ce_clk      (ce_clk),
    .ce_rst      (ce_rst),
    .in_s        (in_if),
    .out_m       (out_if),
    .seg_err_cnt (seg_err_cnt)
  );

  always #5 ce_clk = ~ce_clk;

  int         n_chk = 0;
  int         n_fail = 0;
  bq_t        dl [NB];
  bq_t        il [NB];
  int         mk, mc, m_err;
  beat_t      expq [$];
  logic [7:0] out_log [$];
  logic [7:0] run1 [$];
  logic [7:0] tx [$];
  logic [7:0] src [$];
  bit         stall_prev;
  logic [7:0] hold_d;
  logic       hold_l, hold_u;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each branch is a FIFO pre-loaded with its delay's worth of zeros.
  task automatic model_reset();
    for (int k = 0; k < NB; k++) begin
      dl[k].delete();
      repeat ((NB - 1 - k) * NM) dl[k].push_back(8'h00);
    end
    mk = 0; mc = 0; m_err = 0;
    expq.delete();
    out_log.delete();
    stall_prev = 1'b0;
  endtask

  task automatic model_accept(input logic [7:0] d, input bit u, input bit l);
    beat_t b;
    if (u) begin mk = 0; mc = 0; end
    dl[mk].push_back(d);
    b.d = dl[mk].pop_front();
    b.l = (mc == SEG - 1);
    b.u = u;
    expq.push_back(b);
    if ((l != (mc == SEG - 1)) && m_err < 65535) m_err++;
    mk = (mk + 1) % NB;
    mc = (mc + 1) % SEG;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit v, input logic [7:0] d, input bit u, input bit l,
                      input bit rdy, output bit acc);
    beat_t e;
    if (stall_prev)
      check("stall_hold", 32'({out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser}),
            32'({1'b1, hold_d, hold_l, hold_u}));
    check("out_tvalid", 32'(out_if.tvalid), 32'(expq.size() != 0));
    check("seg_err_cnt", 32'(seg_err_cnt), 32'(m_err));
    in_if.tvalid = v; in_if.tdata = d; in_if.tuser = u; in_if.tlast = l;
    out_if.tready = rdy;
    #1;
    check("in_tready", 32'(in_if.tready), 32'((expq.size() == 0) || rdy));
    if (out_if.tvalid && rdy && expq.size() != 0) begin
      e = expq.pop_front();
      check("out_beat", 32'({out_if.tdata, out_if.tlast, out_if.tuser}), 32'({e.d, e.l, e.u}));
      out_log.push_back(out_if.tdata);
    end
    acc = v && in_if.tready;
    if (acc) model_accept(d, u, l);
    stall_prev = out_if.tvalid && !rdy;
    hold_d = out_if.tdata; hold_l = out_if.tlast; hold_u = out_if.tuser;
    @(posedge ce_clk);
    @(negedge ce_clk);
  endtask

  task automatic send(input logic [7:0] d, input bit u, input bit l, input bit bp);
    bit acc = 1'b0;
    int t = 0;
    while (!acc && t < 1000) begin
      step(1'b1, d, u, l, bp ? ($urandom_range(0, 9) < 3) : 1'b1, acc);
      t++;
    end
    check("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    bit acc;
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc);
    check("drained", 32'(expq.size()), 32'd0);
  endtask

  task automatic sync_reset();
    ce_rst = 1'b1;
    in_if.tvalid = 1'b0;
    @(posedge ce_clk);
    @(negedge ce_clk);
    ce_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int diffs;
    logic [7:0] x;
    in_if.tvalid = 1'b0; in_if.tdata = 8'h00; in_if.tuser = 1'b0; in_if.tlast = 1'b0;
    out_if.tready = 1'b1;
    repeat (2) @(negedge ce_clk);
    ce_rst = 1'b0;
    model_reset();
    check("rst_tvalid", 32'(out_if.tvalid), 32'd0);
    check("rst_tlast", 32'(out_if.tlast), 32'd0);
    check("rst_tuser", 32'(out_if.tuser), 32'd0);
    check("rst_tdata", 32'(out_if.tdata), 32'd0);
    check("rst_err", 32'(seg_err_cnt), 32'd0);

    // Bypass: only branch 51 passes straight through on a fresh field.
    for (int i = 0; i < NB; i++) send(8'(i), i == 0, 1'b0, 1'b0);
    drain();
    check("byp_count", 32'(out_log.size()), 32'd52);
    if (out_log.size() == 52) begin
      for (int i = 0; i < NB - 1; i++) check("byp_unfilled", 32'(out_log[i]), 32'd0);
      check("byp_b51", 32'(out_log[51]), 32'h33);
    end

    // Branch-0 and branch-1 delays on a ramp.
    sync_reset();
    for (int i = 0; i <= FILL; i++)
      send((i == 0) ? 8'hA5 : 8'(i), i == 0, (i % SEG) == SEG - 1, 1'b0);
    drain();
    check("b0_count", 32'(out_log.size()), 32'(FILL + 1));
    if (out_log.size() == FILL + 1) begin
      check("b0_delay", 32'(out_log[FILL]), 32'hA5);
      check("b1_delay", 32'(out_log[1 + 200 * NB]), 32'h01);
    end

    // Round trip through a reference interleaver (branch k delayed k*M).
    sync_reset();
    for (int k = 0; k < NB; k++) begin
      il[k].delete();
      repeat (k * NM) il[k].push_back(8'h00);
    end
    src.delete(); tx.delete();
    for (int j = 0; j < RT_N; j++) begin
      src.push_back(8'($urandom));
      il[j % NB].push_back(src[j]);
      x = il[j % NB].pop_front();
      tx.push_back(x);
    end
    for (int j = 0; j < RT_N; j++) send(tx[j], j == 0, (j % SEG) == SEG - 1, 1'b0);
    drain();
    check("rt_count", 32'(out_log.size()), 32'(RT_N));
    diffs = 0;
    if (out_log.size() == RT_N)
      for (int n = FILL; n < RT_N; n++) if (out_log[n] !== src[n - FILL]) diffs++;
    check("rt_data", 32'(diffs), 32'd0);
    check("rt_err", 32'(seg_err_cnt), 32'd0);
    run1 = out_log;

    // Same stream under 30% output-ready.
    sync_reset();
    for (int j = 0; j < RT_N; j++) send(tx[j], j == 0, (j % SEG) == SEG - 1, 1'b1);
    drain();
    check("bp_count", 32'(out_log.size()), 32'(run1.size()));
    diffs = 0;
    if (out_log.size() == run1.size())
      for (int n = 0; n < RT_N; n++) if (out_log[n] !== run1[n]) diffs++;
    check("bp_data", 32'(diffs), 32'd0);

    // Extra in_tlast on byte 100 of three segments.
    sync_reset();
    for (int j = 0; j < 3 * SEG + 50; j++)
      send(8'($urandom), j == 0,
           ((j % SEG) == SEG - 1) || (j < 3 * SEG && (j % SEG) == 100), 1'b0);
    drain();
    check("mis_err", 32'(seg_err_cnt), 32'd3);

    // Async reset between clock edges with an output pending.
    for (int j = 0; j < 300; j++) send(8'($urandom), j == 0, (j % SEG) == SEG - 1, 1'b0);
    check("pre_rst_valid", 32'(out_if.tvalid), 32'd1);
    #3 ce_rst = 1'b1;
    #1;
    check("arst_valid", 32'(out_if.tvalid), 32'd0);
    check("arst_tdata", 32'(out_if.tdata), 32'd0);
    check("arst_err", 32'(seg_err_cnt), 32'd0);
    in_if.tvalid = 1'b0;
    #4 ce_rst = 1'b0;
    @(negedge ce_clk);
    model_reset();
    for (int i = 0; i < NB; i++) send(8'(i), 1'b0, 1'b0, 1'b0);
    drain();
    check("arst_count", 32'(out_log.size()), 32'd52);
    if (out_log.size() == 52) begin
      for (int i = 0; i < NB - 1; i++) check("arst_masked", 32'(out_log[i]), 32'd0);
      check("arst_b51", 32'(out_log[51]), 32'h33);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
